fetch_align_unit: RTL and testbench

Instruction-fetch front end that feeds the IF/ID register of the pipelined RV32 core. It issues word-aligned fetches to the shared single-port memory and buffers returned halfwords in a small circular queue. From that queue it presents one instruction per handshake, either a full 32-bit instruction or a 16-bit compressed one, together with its PC; 32-bit instructions may straddle a word boundary. It handles taken-branch/jump redirects and downstream stalls. Decompression stays downstream.

---
 rtl/fetch_if.sv | 43 ++++
 rtl/fetch_align_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_align_unit.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Bus bundle between the fetch/align unit, the shared instruction memory port
// and the IF/ID register. The DUT side uses the master modport.
//
// Handshakes:
//   memory  : a request transfers on a cycle with mem_req && mem_gnt. Exactly
//             one mem_rvalid per granted request follows, at least one cycle
//             after the grant. mem_req is never held waiting for a grant:
//             it may drop between cycles without being granted.
//   inst    : an instruction transfers on a cycle with inst_valid && inst_ready.
//             While inst_valid && !inst_ready, inst_data, inst_pc and
//             inst_is_compressed hold their values.
interface fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;

  modport master (
    input  redirect_valid, redirect_pc,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  inst_ready,
    output mem_req, mem_addr,
    output inst_valid, inst_data, inst_pc, inst_is_compressed
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output mem_gnt, mem_rvalid, mem_rdata,
    output inst_ready,
    input  mem_req, mem_addr,
    input  inst_valid, inst_data, inst_pc, inst_is_compressed
  );
endinterface

// File: rtl/fetch_align_unit.sv
// Instruction fetch front end: issues word fetches, buffers the returned
// halfwords in a circular queue and presents one 16- or 32-bit instruction
// per handshake together with its PC. Redirects flush the queue and restart
// fetching; a response still in flight at a redirect is dropped via kill.
module fetch_align_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int PTR_W = $clog2(BUF_HW);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // A request needs room for a whole word, so it is only issued while at
  // least two halfword slots are free.
  localparam cnt_t REQ_LIMIT = cnt_t'(BUF_HW - 2);

  // Halfword queue and its bookkeeping
  logic [15:0] queue_mem [BUF_HW];
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;
  cnt_t        count;

  // Fetch side state
  logic [31:0] fetch_pc;     // next word address to request
  logic [31:0] head_pc;      // PC of the halfword at rd_ptr
  logic        outstanding;  // a granted request has not returned yet
  logic        kill;         // the in-flight response belongs to a flushed stream
  logic        discard_low;  // next accepted word starts at its high halfword

  // Combinational decode of the queue head and the per-cycle transfers
  logic [15:0] h0;
  logic [15:0] h1;
  logic        h0_comp;
  logic        inst_avail;
  logic        req;
  logic        fire;
  logic        resp;
  logic        accept;
  cnt_t        pop_n;
  cnt_t        push_n;

  // Decode the head of the queue and work out pops, pushes and the request.
  always_comb begin
    h0         = queue_mem[rd_ptr];
    h1         = queue_mem[rd_ptr + ptr_t'(1)];
    h0_comp    = (h0[1:0] != 2'b11);
    inst_avail = h0_comp ? (count >= cnt_t'(1)) : (count >= cnt_t'(2));

    req    = !outstanding && (count <= REQ_LIMIT) && !bus.redirect_valid;
    fire   = !rst && inst_avail && !bus.redirect_valid && bus.inst_ready;
    resp   = bus.mem_rvalid && outstanding;
    accept = resp && !kill;

    pop_n = '0;
    if (fire) begin
      pop_n = h0_comp ? cnt_t'(1) : cnt_t'(2);
    end

    push_n = '0;
    if (accept) begin
      push_n = discard_low ? cnt_t'(1) : cnt_t'(2);
    end
  end

  // Drive the bus outputs; everything reads as zero while reset is held.
  always_comb begin
    bus.mem_req            = 1'b0;
    bus.mem_addr           = '0;
    bus.inst_valid         = 1'b0;
    bus.inst_data          = '0;
    bus.inst_pc            = '0;
    bus.inst_is_compressed = 1'b0;
    if (!rst) begin
      bus.mem_req            = req;
      bus.mem_addr           = fetch_pc;
      bus.inst_valid         = inst_avail && !bus.redirect_valid;
      bus.inst_data          = h0_comp ? {16'h0000, h0} : {h1, h0};
      bus.inst_pc            = head_pc;
      bus.inst_is_compressed = h0_comp;
    end
  end

  // Control state: reset, then redirect, then normal fetch/pop/push.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
      head_pc     <= RESET_PC & 32'hFFFF_FFFE;
      discard_low <= RESET_PC[1];
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      kill        <= 1'b0;
    end else if (bus.redirect_valid) begin
      // A response landing in this very cycle is dropped and retires the
      // old request; otherwise the old request stays in flight and is
      // marked for dropping. No new request can be granted this cycle.
      fetch_pc    <= bus.redirect_pc & 32'hFFFF_FFFC;
      head_pc     <= bus.redirect_pc & 32'hFFFF_FFFE;
      discard_low <= bus.redirect_pc[1];
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding && !bus.mem_rvalid;
      kill        <= outstanding && !bus.mem_rvalid;
    end else begin
      // Grant and response cannot coincide: requests need !outstanding.
      if (req && bus.mem_gnt) begin
        outstanding <= 1'b1;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (resp) begin
        outstanding <= 1'b0;
      end

      if (resp) begin
        if (kill) begin
          kill <= 1'b0;
        end else if (discard_low) begin
          discard_low <= 1'b0;
        end
      end

      rd_ptr  <= rd_ptr + ptr_t'(pop_n);
      wr_ptr  <= wr_ptr + ptr_t'(push_n);
      count   <= count - pop_n + push_n;
      head_pc <= head_pc + (32'(pop_n) << 1);
    end
  end

  // Write accepted halfwords into the queue, low halfword first.
  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect_valid && accept) begin
      if (discard_low) begin
        queue_mem[wr_ptr] <= bus.mem_rdata[31:16];
      end else begin
        queue_mem[wr_ptr]              <= bus.mem_rdata[15:0];
        queue_mem[wr_ptr + ptr_t'(1)]  <= bus.mem_rdata[31:16];
      end
    end
  end

  // The request rule must keep the queue from ever holding more than BUF_HW.
  assert property (@(posedge clk) disable iff (rst) count <= cnt_t'(BUF_HW));

endmodule

// File: tb/tb_fetch_align_unit.sv
// Testbench for fetch_align_unit: a single-port memory responder with
// configurable latency/grant rate, and a reference model that decodes the
// instruction stream straight from the memory image.
module tb_fetch_align_unit;

  localparam int BUF_HW = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  fetch_if f();

  fetch_align_unit #(.RESET_PC(32'h0000_0000), .BUF_HW(BUF_HW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int          n_checks;
  int          n_fail;
  int          cyc;

  logic [31:0] mem_img [0:63];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          lat_min;
  int          lat_max;
  int          gnt_pct;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_pc;

  logic        obs_req, obs_gnt, obs_ret, obs_valid, obs_fire, obs_c;
  logic [31:0] obs_addr, obs_ret_addr, obs_pc, obs_data;

  // ---------------- reference model ----------------
  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_img[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] inst_at(input logic [31:0] pc);
    logic [15:0] lo;
    lo = hw_at(pc);
    if (lo[1:0] != 2'b11) return {16'h0000, lo};
    return {hw_at(pc + 32'd2), lo};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: at the falling edge serve the memory port and sample
  // the DUT outputs, then return just after the next rising edge.
  task automatic tick();
    logic [31:0] a;
    int          lat;
    @(negedge clk);
    cyc++;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a            = pend_addr.pop_front();
      void'(pend_due.pop_front());
      f.mem_rvalid = 1'b1;
      f.mem_rdata  = mem_img[a[7:2]];
      obs_ret      = 1'b1;
      obs_ret_addr = a;
    end else begin
      f.mem_rvalid = 1'b0;
      f.mem_rdata  = $urandom;
      obs_ret      = 1'b0;
      obs_ret_addr = '0;
    end
    obs_req  = f.mem_req;
    obs_addr = f.mem_addr;
    if (f.mem_req && pend_addr.size() == 0 && int'($urandom_range(99)) < gnt_pct) begin
      f.mem_gnt = 1'b1;
      lat = int'($urandom_range(lat_max, lat_min));
      pend_addr.push_back(f.mem_addr);
      pend_due.push_back(cyc + lat);
    end else begin
      f.mem_gnt = 1'b0;
    end
    obs_gnt   = f.mem_gnt;
    obs_valid = f.inst_valid;
    obs_fire  = f.inst_valid && f.inst_ready;
    obs_pc    = f.inst_pc;
    obs_data  = f.inst_data;
    obs_c     = f.inst_is_compressed;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input bit flush);
    rst              = 1'b1;
    f.redirect_valid = 1'b0;
    f.redirect_pc    = '0;
    if (flush) begin
      pend_addr.delete();
      pend_due.delete();
    end
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first_valid;
    int t;
    logic [31:0] e_pc, e_data;
    for (int i = 0; i < 64; i++) mem_img[i] = 32'h0000_0001;
    mem_img[0] = 32'h0050_0093;
    mem_img[1] = 32'h4505_0001;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    f.inst_ready = 1'b1;
    rst = 1'b1;
    pend_addr.delete(); pend_due.delete();
    repeat (3) begin
      tick();
      n_checks++;
      if ({obs_req, obs_addr, obs_valid, obs_data, obs_pc, obs_c} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: req=%0b addr=%h valid=%0b data=%h pc=%h c=%0b, all must be 0",
                 obs_req, obs_addr, obs_valid, obs_data, obs_pc, obs_c);
      end
    end
    rst = 1'b0;
    exp_q.delete(); exp_pc_q.delete();
    exp_pc_q.push_back(32'h0); exp_q.push_back(32'h0050_0093);
    exp_pc_q.push_back(32'h4); exp_q.push_back(32'h0000_0001);
    exp_pc_q.push_back(32'h6); exp_q.push_back(32'h0000_4505);
    first_valid = -1;
    t = 0;
    while (exp_q.size() > 0 && t < 40) begin
      tick();
      if (t == 0) begin
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_first_req: req=%0b addr=%h, required req=1 addr=00000000", obs_req, obs_addr);
        end
      end
      if (obs_valid && first_valid < 0) first_valid = t;
      if (obs_fire) begin
        e_pc   = exp_pc_q.pop_front();
        e_data = exp_q.pop_front();
        n_checks++;
        if (obs_pc !== e_pc || obs_data !== e_data || obs_c !== (e_data[1:0] != 2'b11)) begin
          n_fail++;
          $display("FAIL reset_seq: pc=%h data=%h c=%0b, required pc=%h data=%h", obs_pc, obs_data, obs_c, e_pc, e_data);
        end
      end
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_seq_timeout: %0d instructions missing, required 0", exp_q.size());
    end
    n_checks++;
    if (first_valid != 2) begin
      n_fail++;
      $display("FAIL reset_latency: first inst_valid at cycle %0d after release, required 2", first_valid);
    end
  endtask

  task automatic test_straddle();
    bit got8, early, done;
    int t;
    logic [31:0] e_data;
    for (int i = 0; i < 64; i++) mem_img[i] = 32'h0001_0001;
    mem_img[1] = 32'h0093_0001;
    mem_img[2] = 32'hABCD_0050;
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    f.inst_ready = 1'b1;
    apply_reset(1);
    exp_pc = 0; got8 = 0; early = 0; done = 0; t = 0;
    while (!done && t < 60) begin
      tick();
      if (obs_valid && obs_pc == 32'h6 && !got8) early = 1;
      if (obs_fire) begin
        e_data = inst_at(exp_pc);
        n_checks++;
        if (obs_pc !== exp_pc || obs_data !== e_data) begin
          n_fail++;
          $display("FAIL straddle_seq: pc=%h data=%h, required pc=%h data=%h", obs_pc, obs_data, exp_pc, e_data);
        end
        if (exp_pc == 32'h6) begin
          done = 1;
          n_checks++;
          if (obs_data !== 32'h0050_0093 || obs_c !== 1'b0) begin
            n_fail++;
            $display("FAIL straddle_inst: data=%h c=%0b, required 00500093 c=0", obs_data, obs_c);
          end
        end
        exp_pc = exp_pc + ((e_data[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
      if (obs_ret && obs_ret_addr == 32'h8) got8 = 1;
      t++;
    end
    n_checks++;
    if (!done || early) begin
      n_fail++;
      $display("FAIL straddle_wait: done=%0b early_valid=%0b, required done=1 early_valid=0", done, early);
    end
  endtask

  task automatic test_redirect_discard();
    int t;
    bit hit;
    logic [31:0] e_data;
    for (int i = 0; i < 64; i++) mem_img[i] = $urandom;
    mem_img[2] = 32'h4505_0001;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    f.inst_ready = 1'b1;
    apply_reset(1);
    f.redirect_valid = 1'b1;
    f.redirect_pc    = 32'h0000_000B;  // bit 0 must be ignored
    tick();
    n_checks++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_cycle: req=%0b valid=%0b, required 0 0", obs_req, obs_valid);
    end
    f.redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL redir_req: req=%0b addr=%h, required req=1 addr=00000008", obs_req, obs_addr);
    end
    tick();
    n_checks++;
    if (obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_early: valid=%0b at N+2, required 0", obs_valid);
    end
    tick();
    n_checks++;
    if (obs_fire !== 1'b1 || obs_pc !== 32'hA || obs_data !== 32'h0000_4505 || obs_c !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_first: fire=%0b pc=%h data=%h c=%0b, required 1 0000000a 00004505 1",
               obs_fire, obs_pc, obs_data, obs_c);
    end
    exp_pc = 32'hC;
    // Let the stream run, then redirect again mid-flight.
    t = $urandom_range(12, 6);
    repeat (t) begin
      tick();
      if (obs_fire) begin
        e_data = inst_at(exp_pc);
        n_checks++;
        if (obs_pc !== exp_pc || obs_data !== e_data) begin
          n_fail++;
          $display("FAIL redir_stream: pc=%h data=%h, required pc=%h data=%h", obs_pc, obs_data, exp_pc, e_data);
        end
        exp_pc = exp_pc + ((e_data[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
    end
    f.redirect_valid = 1'b1;
    f.redirect_pc    = 32'h0000_000A;
    tick();
    f.redirect_valid = 1'b0;
    hit = 0; t = 0;
    while (!hit && t < 40) begin
      tick();
      if (obs_fire) begin
        hit = 1;
        n_checks++;
        if (obs_pc !== 32'hA || obs_data !== 32'h0000_4505) begin
          n_fail++;
          $display("FAIL redir_again: pc=%h data=%h, required 0000000a 00004505", obs_pc, obs_data);
        end
      end
      t++;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL redir_again_timeout: fire=%0b, required 1", hit);
    end
  endtask

  task automatic test_redirect_outstanding();
    int t, grants;
    bit got_gnt, hit;
    logic [31:0] first_addr, e_data;
    for (int i = 0; i < 64; i++) mem_img[i] = $urandom;
    lat_min = 4; lat_max = 4; gnt_pct = 100;
    f.inst_ready = 1'b1;
    apply_reset(1);
    got_gnt = 0; t = 0;
    while (!got_gnt && t < 20) begin
      tick();
      got_gnt = obs_gnt;
      t++;
    end
    f.redirect_valid = 1'b1;
    f.redirect_pc    = 32'h0000_0040;
    tick();
    f.redirect_valid = 1'b0;
    grants = 0; hit = 0; t = 0; first_addr = '1;
    while (!hit && t < 40) begin
      tick();
      if (obs_fire) begin
        hit = 1;
        e_data = inst_at(32'h40);
        n_checks++;
        if (obs_pc !== 32'h40 || obs_data !== e_data) begin
          n_fail++;
          $display("FAIL kill_first: pc=%h data=%h, required pc=00000040 data=%h", obs_pc, obs_data, e_data);
        end
      end else if (obs_req) begin
        grants++;
        if (grants == 1) first_addr = obs_addr;
      end
      t++;
    end
    n_checks++;
    if (!hit || grants != 1 || first_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL kill_requests: fired=%0b requests=%0d addr=%h, required 1 1 00000040", hit, grants, first_addr);
    end
  endtask

  task automatic test_backpressure();
    bit held;
    logic [31:0] h_pc, h_data, e_data;
    logic h_c;
    for (int i = 0; i < 64; i++) mem_img[i] = $urandom;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    f.inst_ready = 1'b1;
    apply_reset(1);
    exp_pc = 0;
    repeat (7) begin
      tick();
      if (obs_fire) begin
        e_data = inst_at(exp_pc);
        n_checks++;
        if (obs_pc !== exp_pc || obs_data !== e_data) begin
          n_fail++;
          $display("FAIL bp_pre: pc=%h data=%h, required pc=%h data=%h", obs_pc, obs_data, exp_pc, e_data);
        end
        exp_pc = exp_pc + ((e_data[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
    end
    f.inst_ready = 1'b0;
    held = 0; h_pc = '0; h_data = '0; h_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (held) begin
        n_checks++;
        if ({obs_valid, obs_pc, obs_data, obs_c} !== {1'b1, h_pc, h_data, h_c}) begin
          n_fail++;
          $display("FAIL bp_stable: valid=%0b pc=%h data=%h c=%0b, required 1 %h %h %0b",
                   obs_valid, obs_pc, obs_data, obs_c, h_pc, h_data, h_c);
        end
      end else if (obs_valid) begin
        held = 1; h_pc = obs_pc; h_data = obs_data; h_c = obs_c;
        e_data = inst_at(exp_pc);
        n_checks++;
        if (obs_pc !== exp_pc || obs_data !== e_data) begin
          n_fail++;
          $display("FAIL bp_head: pc=%h data=%h, required pc=%h data=%h", obs_pc, obs_data, exp_pc, e_data);
        end
      end
      if (i >= 7) begin
        n_checks++;
        if (obs_req !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_req: mem_req=%0b with full queue, required 0", obs_req);
        end
      end
    end
    f.inst_ready = 1'b1;
    repeat (30) begin
      tick();
      if (obs_fire) begin
        e_data = inst_at(exp_pc);
        n_checks++;
        if (obs_pc !== exp_pc || obs_data !== e_data) begin
          n_fail++;
          $display("FAIL bp_post: pc=%h data=%h, required pc=%h data=%h", obs_pc, obs_data, exp_pc, e_data);
        end
        exp_pc = exp_pc + ((e_data[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
    end
    n_checks++;
    if (exp_pc < 32'h10) begin
      n_fail++;
      $display("FAIL bp_progress: pc reached %h, required at least 00000010", exp_pc);
    end
  endtask

  task automatic test_reset_midfetch();
    int t, fires;
    bit armed;
    logic [31:0] e_data;
    for (int i = 0; i < 64; i++) mem_img[i] = $urandom;
    lat_min = 5; lat_max = 5; gnt_pct = 100;
    f.inst_ready = 1'b1;
    apply_reset(1);
    exp_pc = 0; armed = 0; t = 0;
    while (!armed && t < 100) begin
      tick();
      if (obs_fire) begin
        e_data = inst_at(exp_pc);
        n_checks++;
        if (obs_pc !== exp_pc || obs_data !== e_data) begin
          n_fail++;
          $display("FAIL midrst_pre: pc=%h data=%h, required pc=%h data=%h", obs_pc, obs_data, exp_pc, e_data);
        end
        exp_pc = exp_pc + ((e_data[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
      if (exp_pc >= 32'h8 && obs_gnt && obs_addr != 32'h0) armed = 1;
      t++;
    end
    rst = 1'b1;
    repeat (2) begin
      tick();
      n_checks++;
      if ({obs_req, obs_addr, obs_valid, obs_data, obs_pc, obs_c} !== '0) begin
        n_fail++;
        $display("FAIL midrst_outputs: req=%0b addr=%h valid=%0b data=%h pc=%h c=%0b, all must be 0",
                 obs_req, obs_addr, obs_valid, obs_data, obs_pc, obs_c);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_restart: req=%0b addr=%h, required req=1 addr=00000000", obs_req, obs_addr);
    end
    exp_pc = 0; fires = 0; t = 0;
    while (fires < 4 && t < 80) begin
      tick();
      if (obs_fire) begin
        fires++;
        e_data = inst_at(exp_pc);
        n_checks++;
        if (obs_pc !== exp_pc || obs_data !== e_data) begin
          n_fail++;
          $display("FAIL midrst_post: pc=%h data=%h, required pc=%h data=%h", obs_pc, obs_data, exp_pc, e_data);
        end
        exp_pc = exp_pc + ((e_data[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
      t++;
    end
    n_checks++;
    if (fires < 4) begin
      n_fail++;
      $display("FAIL midrst_timeout: %0d instructions, required 4", fires);
    end
  endtask

  task automatic test_random();
    int fires;
    bit redir;
    logic [31:0] rp, e_data;
    for (int i = 0; i < 64; i++) mem_img[i] = $urandom;
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    apply_reset(1);
    exp_pc = 0; fires = 0;
    for (int i = 0; i < 3000; i++) begin
      f.inst_ready     = (int'($urandom_range(99)) < 75);
      redir            = (int'($urandom_range(99)) < 4);
      rp               = $urandom;
      f.redirect_valid = redir;
      f.redirect_pc    = rp;
      tick();
      if (redir) begin
        n_checks++;
        if (obs_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_redir_valid: inst_valid=%0b during redirect, required 0", obs_valid);
        end
        exp_pc = rp & 32'hFFFF_FFFE;
      end else if (obs_fire) begin
        fires++;
        e_data = inst_at(exp_pc);
        n_checks++;
        if (obs_pc !== exp_pc || obs_data !== e_data || obs_c !== (e_data[1:0] != 2'b11)) begin
          n_fail++;
          $display("FAIL rand_stream: pc=%h data=%h c=%0b, required pc=%h data=%h",
                   obs_pc, obs_data, obs_c, exp_pc, e_data);
        end
        exp_pc = exp_pc + ((e_data[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
    end
    f.redirect_valid = 1'b0;
    n_checks++;
    if (fires < 150) begin
      n_fail++;
      $display("FAIL rand_throughput: %0d instructions, required at least 150", fires);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst              = 1'b1;
    f.redirect_valid = 1'b0;
    f.redirect_pc    = '0;
    f.mem_gnt        = 1'b0;
    f.mem_rvalid     = 1'b0;
    f.mem_rdata      = '0;
    f.inst_ready     = 1'b0;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    test_reset();
    test_straddle();
    test_redirect_discard();
    test_redirect_outstanding();
    test_backpressure();
    test_reset_midfetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at time %0t, required to have finished", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
